// File: rtl/idecode_sb.sv
// rtl/idecode_sb.sv - decode stage with register file and per-register hazard scoreboard
// Optional same-cycle writeback bypass: IDECODE_SB_BYPASS_EN
module idecode_sb #(
  parameter int WORD  = 32,
  parameter int W_OPC = 4,
  parameter int W_RN  = 3,
  parameter int W_IMM = 16,
  parameter logic [(1<<W_OPC)-1:0] WB_MASK   = 16'hFFF0,
  parameter logic [(1<<W_OPC)-1:0] ZEXT_MASK = 16'h00C0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   v_i,
  input  logic [WORD-1:0]        inst_i,
  output logic                   stall_o,
  output logic                   v_o,
  output logic [WORD-1:0]        src_o,
  output logic [WORD-1:0]        dest_o,
  output logic [W_RN-1:0]        rdnum_o,
  output logic                   wb_o,
  output logic [W_OPC-1:0]       dopc_o,
  input  logic                   stall_i,
  input  logic                   wbv_i,
  input  logic [W_RN-1:0]        wbnum_i,
  input  logic [WORD-1:0]        wbdata_i,
  output logic [(1<<W_RN)-1:0]   busy_o
);

  localparam int NREG   = 1 << W_RN;
  localparam int B_IMMF = WORD - W_OPC - 1;
  localparam int B_RD   = B_IMMF - 1;
  localparam int B_RS   = B_RD - W_RN;
  localparam int B_IMM  = B_RS - W_RN;
  localparam int N_LSB  = B_IMM - W_IMM + 1;

  logic [WORD-1:0]  r_rf [NREG];
  logic [NREG-1:0]  r_busy;
  logic             r_v;
  logic [WORD-1:0]  r_src;
  logic [WORD-1:0]  r_dest;
  logic [W_RN-1:0]  r_rdnum;
  logic             r_wb;
  logic [W_OPC-1:0] r_dopc;

  logic [W_OPC-1:0] w_opc;
  logic             w_immf;
  logic [W_RN-1:0]  w_rd;
  logic [W_RN-1:0]  w_rs;
  logic [W_IMM-1:0] w_imm;
  logic [WORD-1:0]  w_imm_ext;
  logic [NREG-1:0]  w_busy_eff;
  logic [WORD-1:0]  w_rs_val;
  logic [WORD-1:0]  w_rd_val;
  logic             w_hold;
  logic             w_hazard;
  logic             w_issue;

  assign w_opc  = inst_i[WORD-1 -: W_OPC];
  assign w_immf = inst_i[B_IMMF];
  assign w_rd   = inst_i[B_RD -: W_RN];
  assign w_rs   = inst_i[B_RS -: W_RN];
  assign w_imm  = inst_i[B_IMM -: W_IMM];

  generate
    if (N_LSB > 0) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^inst_i[N_LSB-1:0];
    end
  endgenerate

  assign w_imm_ext = {{(WORD-W_IMM){w_imm[W_IMM-1] & ~ZEXT_MASK[w_opc]}}, w_imm};

`ifdef IDECODE_SB_BYPASS_EN
  // A register being written back this cycle is already resolved: forward wbdata_i.
  logic [NREG-1:0] w_wb_hit;
  assign w_wb_hit   = wbv_i ? ({{(NREG-1){1'b0}}, 1'b1} << wbnum_i) : '0;
  assign w_busy_eff = r_busy & ~w_wb_hit;
  assign w_rs_val   = (wbv_i && wbnum_i == w_rs) ? wbdata_i : r_rf[w_rs];
  assign w_rd_val   = (wbv_i && wbnum_i == w_rd) ? wbdata_i : r_rf[w_rd];
`else
  assign w_busy_eff = r_busy;
  assign w_rs_val   = r_rf[w_rs];
  assign w_rd_val   = r_rf[w_rd];
`endif

  assign w_hold   = r_v & stall_i;
  assign w_hazard = v_i & (w_busy_eff[w_rd] | (~w_immf & w_busy_eff[w_rs]));
  assign w_issue  = v_i & ~w_hazard & ~w_hold;
  assign stall_o  = w_hold | w_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v     <= 1'b0;
      r_src   <= '0;
      r_dest  <= '0;
      r_rdnum <= '0;
      r_wb    <= 1'b0;
      r_dopc  <= '0;
      r_busy  <= '0;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      if (!w_hold) begin
        r_v <= w_issue;
        if (w_issue) begin
          r_src   <= w_immf ? w_imm_ext : w_rs_val;
          r_dest  <= w_rd_val;
          r_rdnum <= w_rd;
          r_wb    <= WB_MASK[w_opc];
          r_dopc  <= w_opc;
        end
      end
      if (wbv_i) begin
        r_busy[wbnum_i] <= 1'b0;
        r_rf[wbnum_i]   <= wbdata_i;
      end
      // Issued after the clear so a new pending writer wins over a same-cycle writeback.
      if (w_issue && WB_MASK[w_opc]) r_busy[w_rd] <= 1'b1;
    end
  end

  assign v_o     = r_v;
  assign src_o   = r_src;
  assign dest_o  = r_dest;
  assign rdnum_o = r_rdnum;
  assign wb_o    = r_wb;
  assign dopc_o  = r_dopc;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_idecode_sb.sv
// tb/tb_idecode_sb.sv - directed self-checking bench for idecode_sb
module tb_idecode_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic        stall_o;
  logic        v_o;
  logic [31:0] src_o;
  logic [31:0] dest_o;
  logic [2:0]  rdnum_o;
  logic        wb_o;
  logic [3:0]  dopc_o;
  logic        stall_i = 1'b0;
  logic        wbv_i = 1'b0;
  logic [2:0]  wbnum_i = '0;
  logic [31:0] wbdata_i = '0;
  logic [7:0]  busy_o;

  int n_vec = 0;
  int n_err = 0;

  idecode_sb dut (
    .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .stall_o(stall_o),
    .v_o(v_o), .src_o(src_o), .dest_o(dest_o), .rdnum_o(rdnum_o), .wb_o(wb_o),
    .dopc_o(dopc_o), .stall_i(stall_i), .wbv_i(wbv_i), .wbnum_i(wbnum_i),
    .wbdata_i(wbdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] opc, input logic immf,
                                     input logic [2:0] rd, input logic [2:0] rs,
                                     input logic [15:0] imm);
    return {opc, immf, rd, rs, imm, 5'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [2:0] n, input logic [31:0] d);
    wbv_i = 1'b1; wbnum_i = n; wbdata_i = d;
  endtask

  initial begin
    #1;
    check("rst_v", {31'b0, v_o}, 32'd0);
    check("rst_busy", {24'b0, busy_o}, 32'd0);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_src", src_o, 32'd0);
    tick();
    rst = 1'b1;

    // sign vs zero extension
    v_i = 1'b1; inst_i = mk(4'd4, 1'b1, 3'd1, 3'd0, 16'h8001);
    #1 check("sext_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("sext_v", {31'b0, v_o}, 32'd1);
    check("sext_src", src_o, 32'hFFFF8001);
    check("sext_wb", {31'b0, wb_o}, 32'd1);
    check("sext_rd", {29'b0, rdnum_o}, 32'd1);
    check("sext_busy", {24'b0, busy_o}, 32'h02);
    inst_i = mk(4'd6, 1'b1, 3'd7, 3'd0, 16'h8001);
    tick();
    check("zext_src", src_o, 32'h00008001);
    check("zext_opc", {28'b0, dopc_o}, 32'd6);
    check("zext_busy", {24'b0, busy_o}, 32'h82);

    // retire r1 and r7 with no instruction offered
    v_i = 1'b0; wb(3'd1, 32'hAAAA);
    tick();
    check("idle_v", {31'b0, v_o}, 32'd0);
    check("wb1_busy", {24'b0, busy_o}, 32'h80);
    wb(3'd7, 32'h5555);
    tick();
    wbv_i = 1'b0;
    check("wb7_busy", {24'b0, busy_o}, 32'h00);
    v_i = 1'b1; inst_i = mk(4'd0, 1'b0, 3'd1, 3'd7, 16'h0);
    tick();
    check("rd_src", src_o, 32'h5555);
    check("rd_dest", dest_o, 32'hAAAA);
    check("rd_wb", {31'b0, wb_o}, 32'd0);

    // RAW on r2 resolved by writeback
    inst_i = mk(4'd4, 1'b1, 3'd2, 3'd0, 16'h0010);
    tick();
    check("raw_busy", {24'b0, busy_o}, 32'h04);
    inst_i = mk(4'd0, 1'b0, 3'd0, 3'd2, 16'h0);
    #1 check("raw_stall", {31'b0, stall_o}, 32'd1);
    tick();
    check("raw_v", {31'b0, v_o}, 32'd0);
    wb(3'd2, 32'h1234);
`ifdef IDECODE_SB_BYPASS_EN
    #1 check("byp_stall", {31'b0, stall_o}, 32'd0);
    tick();
    wbv_i = 1'b0;
`else
    #1 check("nobyp_stall", {31'b0, stall_o}, 32'd1);
    tick();
    wbv_i = 1'b0;
    check("nobyp_v0", {31'b0, v_o}, 32'd0);
    #1 check("nobyp_stall2", {31'b0, stall_o}, 32'd0);
    tick();
`endif
    check("raw_v1", {31'b0, v_o}, 32'd1);
    check("raw_src", src_o, 32'h1234);
    check("raw_busy0", {24'b0, busy_o}, 32'h00);

    // downstream hold for 3 cycles
    inst_i = mk(4'd5, 1'b1, 3'd3, 3'd0, 16'h0042);
    tick();
    check("hold0_src", src_o, 32'h42);
    stall_i = 1'b1; inst_i = mk(4'd4, 1'b1, 3'd4, 3'd0, 16'h0077);
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", {31'b0, stall_o}, 32'd1);
      tick();
      check("hold_v", {31'b0, v_o}, 32'd1);
      check("hold_src", src_o, 32'h42);
      check("hold_rd", {29'b0, rdnum_o}, 32'd3);
      check("hold_busy", {24'b0, busy_o}, 32'h08);
    end
    stall_i = 1'b0;
    #1 check("rel_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("rel_src", src_o, 32'h77);
    check("rel_rd", {29'b0, rdnum_o}, 32'd4);
    check("rel_busy", {24'b0, busy_o}, 32'h18);

    // same-cycle issue and writeback to r5: set wins
    inst_i = mk(4'd4, 1'b1, 3'd5, 3'd0, 16'h0001); wb(3'd5, 32'h99);
    tick();
    wbv_i = 1'b0;
    check("sw_v", {31'b0, v_o}, 32'd1);
    check("sw_busy", {24'b0, busy_o}, 32'h38);

    // opcode 1 does not write back
    v_i = 1'b0; wb(3'd3, 32'h33);
    tick();
    wbv_i = 1'b0;
    check("wb3_busy", {24'b0, busy_o}, 32'h30);
    v_i = 1'b1; inst_i = mk(4'd1, 1'b1, 3'd3, 3'd0, 16'h0);
    tick();
    check("op1_wb", {31'b0, wb_o}, 32'd0);
    check("op1_busy", {24'b0, busy_o}, 32'h30);
    inst_i = mk(4'd0, 1'b0, 3'd0, 3'd3, 16'h0);
    #1 check("op1_rdr_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("op1_rdr_v", {31'b0, v_o}, 32'd1);
    check("op1_rdr_src", src_o, 32'h33);

    // asynchronous reset in the middle of a downstream hold
    stall_i = 1'b1; inst_i = mk(4'd4, 1'b1, 3'd6, 3'd0, 16'h0002);
    #1 check("mid_stall", {31'b0, stall_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_v", {31'b0, v_o}, 32'd0);
    check("arst_busy", {24'b0, busy_o}, 32'd0);
    check("arst_stall", {31'b0, stall_o}, 32'd0);
    check("arst_src", src_o, 32'd0);
    tick();
    rst = 1'b1; stall_i = 1'b0; inst_i = mk(4'd4, 1'b1, 3'd1, 3'd0, 16'h0005);
    tick();
    check("post_v", {31'b0, v_o}, 32'd1);
    check("post_src", src_o, 32'h5);
    inst_i = mk(4'd0, 1'b0, 3'd0, 3'd3, 16'h0);
    tick();
    check("post_rf_clr", src_o, 32'd0);
    v_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
